// File: rtl/mac_tx_framer_if.sv
// rtl/mac_tx_framer_if.sv - upstream byte handshake between frame generator and tx framer
interface mac_tx_framer_if;
    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack;

    modport master (output mac_tx_data, output mac_tx_dvld, input mac_tx_ack);
    modport slave  (input mac_tx_data, input mac_tx_dvld, output mac_tx_ack);
endinterface

// File: rtl/mac_tx_framer.sv
// rtl/mac_tx_framer.sv - GMII transmit framer: preamble/SFD, pad, CRC-32 FCS, inter-frame gap
module mac_tx_framer #(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME     = 60,
    parameter int MAX_PAYLOAD   = 1514,
    parameter int JUMBO_PAYLOAD = 9014,
    parameter int IFG_BYTES     = 12
) (
    input  logic           tx_clk,
    input  logic           reset_n,
    input  logic           conf_tx_en,
    input  logic           conf_tx_jumbo_en,
    input  logic           conf_tx_no_gen_crc,
    mac_tx_framer_if.slave up,
    output logic [7:0]     gmii_txd,
    output logic           gmii_tx_en,
    output logic           gmii_tx_er,
    output logic           frame_done,
    output logic           frame_err
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state, next_state, after_data;
    logic [3:0]  step, next_step;
    logic [13:0] byte_cnt, next_byte_cnt, cnt_inc, limit;
    logic [31:0] crc, next_crc, fcs;
    logic        jumbo_q, no_crc_q, next_jumbo, next_no_crc;
    logic        err_flag, next_err_flag;
    logic        start;
    logic [7:0]  txd_d;
    logic        tx_en_d, tx_er_d, ack_d, done_d, err_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign start      = conf_tx_en && up.mac_tx_dvld;
    assign cnt_inc    = (byte_cnt == 14'h3FFF) ? byte_cnt : byte_cnt + 14'd1;
    assign limit      = (jumbo_q ? 14'(JUMBO_PAYLOAD) : 14'(MAX_PAYLOAD)) + (no_crc_q ? 14'd4 : 14'd0);
    assign fcs        = ~crc;
    assign after_data = no_crc_q ? IFG : ((byte_cnt < 14'(MIN_FRAME)) ? PAD : FCS);

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            step  <= 4'd0;
        end else begin
            state <= next_state;
            step  <= next_step;
        end
    end

    // step counts cycles spent in the current state; restarts on every transition
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = PREAMBLE;
            PREAMBLE: if (step == 4'(PREAMBLE_LEN - 1)) next_state = SFD;
            SFD, DATA: next_state = up.mac_tx_dvld ? DATA : after_data;
            PAD:      if (byte_cnt >= 14'(MIN_FRAME)) next_state = FCS;
            FCS:      if (step == 4'd3) next_state = IFG;
            IFG:      if (step == 4'(IFG_BYTES - 1)) next_state = start ? PREAMBLE : IDLE;
            default:  next_state = IDLE;
        endcase
        next_step = (next_state == state) ? step + 4'd1 : 4'd0;
    end

    // Outputs are computed for the state being entered, so the registers line up with it
    always_comb begin
        next_byte_cnt = byte_cnt;
        next_crc      = crc;
        next_jumbo    = jumbo_q;
        next_no_crc   = no_crc_q;
        next_err_flag = err_flag;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        ack_d         = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        case (next_state)
            PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h55;
                if (state != PREAMBLE) begin
                    next_byte_cnt = 14'd0;
                    next_crc      = 32'hFFFFFFFF;
                    next_jumbo    = conf_tx_jumbo_en;
                    next_no_crc   = conf_tx_no_gen_crc;
                    next_err_flag = 1'b0;
                end
            end
            SFD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'hD5;
                ack_d   = 1'b1;
            end
            DATA: begin
                tx_en_d       = 1'b1;
                txd_d         = up.mac_tx_data;
                next_byte_cnt = cnt_inc;
                next_crc      = crc32_byte(crc, up.mac_tx_data);
                if (cnt_inc > limit) begin
                    tx_er_d       = 1'b1;
                    next_err_flag = 1'b1;
                end
            end
            PAD: begin
                tx_en_d       = 1'b1;
                next_byte_cnt = cnt_inc;
                next_crc      = crc32_byte(crc, 8'h00);
            end
            FCS: begin
                tx_en_d = 1'b1;
                case (next_step[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
            end
            IFG: begin
                if (state != IFG) begin
                    done_d        = 1'b1;
                    err_d         = err_flag;
                    next_err_flag = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt      <= 14'd0;
            crc           <= 32'hFFFFFFFF;
            jumbo_q       <= 1'b0;
            no_crc_q      <= 1'b0;
            err_flag      <= 1'b0;
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            up.mac_tx_ack <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            byte_cnt      <= next_byte_cnt;
            crc           <= next_crc;
            jumbo_q       <= next_jumbo;
            no_crc_q      <= next_no_crc;
            err_flag      <= next_err_flag;
            gmii_txd      <= txd_d;
            gmii_tx_en    <= tx_en_d;
            gmii_tx_er    <= tx_er_d;
            up.mac_tx_ack <= ack_d;
            frame_done    <= done_d;
            frame_err     <= err_d;
        end
    end
endmodule

// File: tb/tb_mac_tx_framer.sv
// tb/tb_mac_tx_framer.sv - table-driven bench for mac_tx_framer
module tb_mac_tx_framer;
    logic       tx_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       conf_tx_en = 1'b0;
    logic       conf_tx_jumbo_en = 1'b0;
    logic       conf_tx_no_gen_crc = 1'b0;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, frame_done, frame_err;

    mac_tx_framer_if up();

    mac_tx_framer dut (
        .tx_clk             (tx_clk),
        .reset_n            (reset_n),
        .conf_tx_en         (conf_tx_en),
        .conf_tx_jumbo_en   (conf_tx_jumbo_en),
        .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
        .up                 (up),
        .gmii_txd           (gmii_txd),
        .gmii_tx_en         (gmii_tx_en),
        .gmii_tx_er         (gmii_tx_er),
        .frame_done         (frame_done),
        .frame_err          (frame_err)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int kind; int len; bit jumbo; bit ncrc;
        int txen; int er_cnt; int first_er; int err;
    } vec_t;

    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] q_txd[$];
    logic       q_er[$];
    int         seg_len[$];
    int         gap_len[$];
    int         ack_cnt, done_cnt, err_cnt, err_alone;
    bit         run_done;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int kind, input int i);
        if (kind == 0) begin
            if (i < 6)   return 8'hFF;
            if (i == 6)  return 8'h02;
            if (i == 11) return 8'h01;
            if (i < 12)  return 8'h00;
            if (i == 12) return 8'h08;
            if (i == 13) return 8'h06;
            return 8'(i * 3 + 1);
        end
        return 8'(i * 7 + kind * 29 + 5);
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Drives one or two frames (len1 < 0 means one) and records the GMII side
    task automatic run(input int kind0, input int len0, input int kind1, input int len1, input int abort_at);
        int nfr, cur, idx, budget, after_done, cur_seg, cur_gap;
        bit acked, took, ending, in_seg;
        int kinds[2];
        int lens[2];
        kinds[0] = kind0; kinds[1] = kind1; lens[0] = len0; lens[1] = len1;
        q_txd.delete(); q_er.delete(); seg_len.delete(); gap_len.delete();
        ack_cnt = 0; done_cnt = 0; err_cnt = 0; err_alone = 0; run_done = 0;
        nfr = (len1 >= 0) ? 2 : 1;
        cur = 0; idx = 0; acked = 0; ending = 0; in_seg = 0; cur_seg = 0; cur_gap = 0;
        after_done = 0;
        up.mac_tx_dvld = 1'b1;
        up.mac_tx_data = pay(kind0, 0);
        for (budget = 0; budget < 20000; budget++) begin
            @(negedge tx_clk);
            if (gmii_tx_en) begin
                if (!in_seg && seg_len.size() > 0) gap_len.push_back(cur_gap);
                q_txd.push_back(gmii_txd);
                q_er.push_back(gmii_tx_er);
                in_seg = 1; cur_seg++;
            end else begin
                if (in_seg) begin seg_len.push_back(cur_seg); cur_seg = 0; cur_gap = 0; end
                in_seg = 0; cur_gap++;
            end
            if (up.mac_tx_ack) ack_cnt++;
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (frame_err && !frame_done) err_alone++;
            if (abort_at >= 0 && q_txd.size() == abort_at) begin
                #2 reset_n = 1'b0;
                #1 check("abort_outputs_zero",
                         {gmii_tx_en, gmii_tx_er, frame_done, frame_err, up.mac_tx_ack, gmii_txd}, 0);
                up.mac_tx_dvld = 1'b0;
                @(negedge tx_clk);
                @(negedge tx_clk);
                reset_n = 1'b1;
                run_done = 1;
                return;
            end
            if (done_cnt == nfr) after_done++;
            if (after_done > 14) begin run_done = 1; break; end
            if (up.mac_tx_ack) acked = 1;
            took = acked && up.mac_tx_dvld;
            @(posedge tx_clk);
            #1;
            if (took) idx++;
            if (ending) begin
                ending = 0; cur++; idx = 0; acked = 0;
                if (cur < nfr) begin
                    up.mac_tx_dvld = 1'b1;
                    up.mac_tx_data = pay(kinds[cur], 0);
                end
            end else if (cur < nfr && acked && idx == lens[cur]) begin
                up.mac_tx_dvld = 1'b0;
                ending = 1;
            end else if (cur < nfr) begin
                up.mac_tx_data = pay(kinds[cur], idx);
            end
        end
        up.mac_tx_dvld = 1'b0;
        check("run_completes", run_done, 1);
    endtask

    task automatic check_frame(input string name, input int off, input int kind, input int len, input bit ncrc);
        logic [7:0]  e[$];
        logic [31:0] c, r, rev;
        int bad;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int i = 0; i < len; i++) begin e.push_back(pay(kind, i)); c = crc_step(c, pay(kind, i)); end
        if (!ncrc) begin
            for (int i = len; i < 60; i++) begin e.push_back(8'h00); c = crc_step(c, 8'h00); end
            c = ~c;
            for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        end
        bad = 0;
        for (int i = 0; i < e.size(); i++)
            if (off + i >= q_txd.size() || q_txd[off + i] !== e[i]) bad++;
        check({name, "_bytes"}, bad, 0);
        if (!ncrc) begin
            r = 32'hFFFFFFFF;
            for (int i = off + 8; i < off + e.size() && i < q_txd.size(); i++) r = crc_step(r, q_txd[i]);
            for (int b = 0; b < 32; b++) rev[b] = r[31 - b];
            check({name, "_residue"}, rev, 32'hC704DD7B);
        end
    endtask

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, er_n, first_er;
        vecs[0] = '{0,   60, 0, 0,   72, 0,   -1, 0};
        vecs[1] = '{1,   14, 0, 0,   72, 0,   -1, 0};
        vecs[2] = '{2,   64, 0, 1,   72, 0,   -1, 0};
        vecs[3] = '{3,   14, 0, 1,   22, 0,   -1, 0};
        vecs[4] = '{4, 1516, 0, 0, 1528, 2, 1522, 1};
        vecs[5] = '{4, 1516, 1, 0, 1528, 0,   -1, 0};
        vecs[6] = '{5,   61, 0, 0,   73, 0,   -1, 0};
        vecs[7] = '{6, 1518, 0, 1, 1526, 0,   -1, 0};
        vecs[8] = '{7, 1519, 0, 1, 1527, 1, 1526, 1};

        up.mac_tx_dvld = 1'b0;
        up.mac_tx_data = 8'h00;
        repeat (3) @(negedge tx_clk);
        check("reset_outputs", {gmii_tx_en, gmii_tx_er, frame_done, frame_err, up.mac_tx_ack, gmii_txd}, 0);
        reset_n = 1'b1;

        up.mac_tx_dvld = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge tx_clk);
            if (gmii_tx_en || up.mac_tx_ack) cnt++;
        end
        check("disabled_holds_idle", cnt, 0);
        up.mac_tx_dvld = 1'b0;
        conf_tx_en = 1'b1;
        @(negedge tx_clk);

        for (int v = 0; v < 9; v++) begin
            conf_tx_jumbo_en   = vecs[v].jumbo;
            conf_tx_no_gen_crc = vecs[v].ncrc;
            run(vecs[v].kind, vecs[v].len, 0, -1, -1);
            check($sformatf("v%0d_segments", v), seg_len.size(), 1);
            check($sformatf("v%0d_txen_len", v), (seg_len.size() > 0) ? seg_len[0] : -1, vecs[v].txen);
            check($sformatf("v%0d_ack", v), ack_cnt, 1);
            check($sformatf("v%0d_done", v), done_cnt, 1);
            check($sformatf("v%0d_err", v), err_cnt, vecs[v].err);
            check($sformatf("v%0d_err_alone", v), err_alone, 0);
            er_n = 0; first_er = -1;
            for (int i = 0; i < q_er.size(); i++)
                if (q_er[i]) begin er_n++; if (first_er < 0) first_er = i; end
            check($sformatf("v%0d_er_count", v), er_n, vecs[v].er_cnt);
            check($sformatf("v%0d_first_er", v), first_er, vecs[v].first_er);
            check_frame($sformatf("v%0d", v), 0, vecs[v].kind, vecs[v].len, vecs[v].ncrc);
        end
        conf_tx_jumbo_en   = 1'b0;
        conf_tx_no_gen_crc = 1'b0;

        run(0, 60, 1, 20, -1);
        check("b2b_segments", seg_len.size(), 2);
        check("b2b_len0", (seg_len.size() > 0) ? seg_len[0] : -1, 72);
        check("b2b_len1", (seg_len.size() > 1) ? seg_len[1] : -1, 72);
        check("b2b_gap", (gap_len.size() > 0) ? gap_len[0] : -1, 12);
        check("b2b_done", done_cnt, 2);
        check("b2b_ack", ack_cnt, 2);
        check_frame("b2b_f0", 0, 0, 60, 0);
        check_frame("b2b_f1", 72, 1, 20, 0);

        run(1, 40, 0, -1, 28);
        run(2, 30, 0, -1, -1);
        check("post_reset_segments", seg_len.size(), 1);
        check("post_reset_len", (seg_len.size() > 0) ? seg_len[0] : -1, 72);
        check("post_reset_done", done_cnt, 1);
        check("post_reset_err", err_cnt, 0);
        check_frame("post_reset", 0, 2, 30, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
